// File: rtl/mem_bus_responder_pkg.sv
// Shared types and defaults for the memory bus responder.
// State encoding, captured-request bundle and byte-lane helper.
package mem_bus_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int DEF_DEPTH_WORDS = 256;
   localparam int DEF_WAIT_STATES = 2;

   typedef struct packed {
      logic        write;
      logic        is_byte;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   function automatic logic [3:0] lane_mask(
      input logic       is_byte,
      input logic [1:0] off
   );
      logic [3:0] m;
      m = 4'hF;
      if (is_byte) begin
         m = 4'b0001 << off;
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Request/response handshake bundle between a requester
// (master) and the memory responder (slave).
interface mem_bus_if;

   logic        req_valid;
   logic        req_write;
   logic        req_byte;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid,
      output req_write,
      output req_byte,
      output req_addr,
      output req_wdata,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_byte,
      input  req_addr,
      input  req_wdata,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );

endinterface

// File: rtl/mem_bus_storage.sv
// Word array with per-lane write enables and a registered read port.
// Contents are deliberately not reset.
module mem_bus_storage #(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic [3:0]    we_i,
   input  logic          re_i,
   input  logic [AW-1:0] idx_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int l = 0; l < 4; l++) begin
         if (we_i[l]) begin
            mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: IDLE -> WAIT (fixed wait
// states) -> RESP, with range/alignment checking and byte stores.
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic clk,
   input  logic reset,
   mem_bus_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, req_d;
   logic        err_q, err_d;
   logic        ld_q, ld_d;

   logic          oor, mis, bad;
   logic [3:0]    we;
   logic          re;
   logic [AW-1:0] idx;
   logic [31:0]   st_wdata;
   logic [31:0]   mem_rdata;

   assign oor = |req_q.addr[31:AW+2];
   assign mis = !req_q.is_byte && (req_q.addr[1:0] != 2'b00);
   assign bad = oor | mis;
   assign idx = req_q.addr[AW+1:2];
   assign st_wdata = req_q.is_byte ? {4{req_q.wdata[7:0]}}
                                   : req_q.wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
         ld_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
         ld_q    <= ld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      ld_d    = ld_q;
      we      = 4'b0000;
      re      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               req_d.write   = bus.req_write;
               req_d.is_byte = bus.req_byte;
               req_d.addr    = bus.req_addr;
               req_d.wdata   = bus.req_wdata;
               cnt_d         = WS;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               err_d   = bad;
               ld_d    = !req_q.write && !bad;
               re      = ld_d;
               state_d = ST_RESP;
               if (req_q.write && !bad) begin
                  we = lane_mask(req_q.is_byte, req_q.addr[1:0]);
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               err_d   = 1'b0;
               ld_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A commit edge that coincides with reset must not reach the array.
   mem_bus_storage #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_storage (
      .clk_i  (clk),
      .we_i   (we & {4{~reset}}),
      .re_i   (re),
      .idx_i  (idx),
      .wdata_i(st_wdata),
      .rdata_o(mem_rdata)
   );

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = (state_q == ST_RESP);
   assign bus.resp_err   = err_q;
   assign bus.resp_rdata = ld_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed, table-driven bench for mem_bus_responder (WAIT_STATES=2)
// plus a WAIT_STATES=0 instance for back-to-back throughput.
module tb_mem_bus_responder;

   localparam int WS = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_if bus();
   mem_bus_if bus0();

   mem_bus_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(WS)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   mem_bus_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(0)
   ) dut0 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus0)
   );

   typedef struct {
      string       nm;
      logic        wr;
      logic        by;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_byte  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
   endtask

   task automatic drive(input logic wr, input logic by,
                        input logic [31:0] a, input logic [31:0] d);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_byte  = by;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

   // Issue one transaction, check latency and the response, handshake it.
   task automatic txn(input string nm, input logic wr, input logic by,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
      int n;
      @(negedge clk);
      chk({nm, "_rdy"}, 32'(bus.req_ready), 32'd1);
      drive(wr, by, a, d);
      @(posedge clk);
      #1;
      idle_req();
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_lat"}, 32'(n), 32'(WS + 1));
      @(negedge clk);
      chk({nm, "_rdata"}, bus.resp_rdata, exp_rd);
      chk({nm, "_err"}, 32'(bus.resp_err), 32'(exp_err));
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      chk({nm, "_done"}, {30'b0, bus.resp_valid, bus.req_ready}, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] d0_rd [3];
      logic        d0_er [3];

      idle_req();
      bus.resp_ready  = 1'b0;
      bus0.req_valid  = 1'b0;
      bus0.req_write  = 1'b0;
      bus0.req_byte   = 1'b0;
      bus0.req_addr   = 32'h0;
      bus0.req_wdata  = 32'h0;
      bus0.resp_ready = 1'b1;

      vt.push_back('{"st10",   1, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0});
      vt.push_back('{"ld10",   0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0});
      vt.push_back('{"st10b",  1, 0, 32'h10,  32'h11223344, 32'h0,        0});
      vt.push_back('{"sb12",   1, 1, 32'h12,  32'hFFFFFFAB, 32'h0,        0});
      vt.push_back('{"ld10b",  0, 0, 32'h10,  32'h0,        32'h11AB3344, 0});
      vt.push_back('{"ld13",   0, 0, 32'h13,  32'h0,        32'h0,        1});
      vt.push_back('{"st00",   1, 0, 32'h0,   32'h12345678, 32'h0,        0});
      vt.push_back('{"st400",  1, 0, 32'h400, 32'h55555555, 32'h0,        1});
      vt.push_back('{"sb401",  1, 1, 32'h401, 32'h000000EE, 32'h0,        1});
      vt.push_back('{"ld00",   0, 0, 32'h0,   32'h0,        32'h12345678, 0});
      vt.push_back('{"sb13",   1, 1, 32'h13,  32'h00000099, 32'h0,        0});
      vt.push_back('{"sb11",   1, 1, 32'h11,  32'h12345600, 32'h0,        0});
      vt.push_back('{"lb11",   0, 1, 32'h11,  32'h0,        32'h99AB0044, 0});
      vt.push_back('{"st3fc",  1, 0, 32'h3FC, 32'h0BADF00D, 32'h0,        0});
      vt.push_back('{"ld3fc",  0, 0, 32'h3FC, 32'h0,        32'h0BADF00D, 0});
      vt.push_back('{"st20",   1, 0, 32'h20,  32'h01020304, 32'h0,        0});
      vt.push_back('{"st22",   1, 0, 32'h22,  32'hFFFFFFFF, 32'h0,        1});
      vt.push_back('{"ld20",   0, 0, 32'h20,  32'h0,        32'h01020304, 0});

      // Reset values while reset is held
      #2;
      chk("rst_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
      chk("rst_err", 32'(bus.resp_err), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd1);

      foreach (vt[i]) begin
         txn(vt[i].nm, vt[i].wr, vt[i].by, vt[i].addr, vt[i].wdata,
             vt[i].rdata, vt[i].err);
      end

      // Stall in RESP while the request inputs churn
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h10, 32'h0);
      @(posedge clk);
      #1;
      idle_req();
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("stall_lat", 32'(n), 32'(WS + 1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1'b1, k[0], 32'h10 + 32'(k), $urandom);
         #1;
         chk("stall_valid", 32'(bus.resp_valid), 32'd1);
         chk("stall_rdata", bus.resp_rdata, 32'h99AB0044);
         chk("stall_err", 32'(bus.resp_err), 32'd0);
         chk("stall_ready", 32'(bus.req_ready), 32'd0);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h10, 32'h0);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      chk("hs_valid", 32'(bus.resp_valid), 32'd0);
      chk("hs_ready", 32'(bus.req_ready), 32'd1);
      idle_req();
      txn("ld10_post", 1'b0, 1'b0, 32'h10, 32'h0, 32'h99AB0044, 1'b0);

      // Reset in the middle of a store's WAIT
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      idle_req();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rw_valid", 32'(bus.resp_valid), 32'd0);
      chk("rw_rdata", bus.resp_rdata, 32'd0);
      chk("rw_err", 32'(bus.resp_err), 32'd0);
      chk("rw_ready", 32'(bus.req_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      txn("ld20_abort", 1'b0, 1'b0, 32'h20, 32'h0, 32'h01020304, 1'b0);

      // Reset while a committed store sits in RESP
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h24, 32'h0A0B0C0D);
      @(posedge clk);
      #1;
      idle_req();
      n = 0;
      while (!bus.resp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rr_lat", 32'(n), 32'(WS + 1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rr_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      txn("ld24_keep", 1'b0, 1'b0, 32'h24, 32'h0, 32'h0A0B0C0D, 1'b0);

      // Zero wait states, resp_ready tied high: one transaction per 3 cycles
      d0_rd[0] = 32'h0;
      d0_er[0] = 1'b0;
      d0_rd[1] = 32'h5A5A5A5A;
      d0_er[1] = 1'b0;
      d0_rd[2] = 32'h0;
      d0_er[2] = 1'b1;
      @(negedge clk);
      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b1;
      bus0.req_addr  = 32'h40;
      bus0.req_wdata = 32'h5A5A5A5A;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("ws0_acc_valid", 32'(bus0.resp_valid), 32'd0);
         chk("ws0_acc_ready", 32'(bus0.req_ready), 32'd0);
         bus0.req_write = 1'b0;
         bus0.req_addr  = (i == 0) ? 32'h40 : 32'h41;
         bus0.req_valid = (i < 2);
         @(posedge clk);
         #1;
         chk("ws0_resp_valid", 32'(bus0.resp_valid), 32'd1);
         chk("ws0_resp_rdata", bus0.resp_rdata, d0_rd[i]);
         chk("ws0_resp_err", 32'(bus0.resp_err), 32'(d0_er[i]));
         @(posedge clk);
         #1;
         chk("ws0_idle", {30'b0, bus0.resp_valid, bus0.req_ready}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
